// File: rtl/ubutterfly_s2b_if.sv
// Result bus of the stochastic-to-binary decoder: sample enable, window start,
// the four butterfly bitstreams, and the valid/ready result handshake.
// The decoder takes the slave side; stimulus and result consumer take the master side.
interface ubutterfly_s2b_if #(
    parameter int unsigned BITWIDTH = 8
) ();
    logic                       iEn;
    logic                       iStart;
    logic                       iReal0;
    logic                       iImg0;
    logic                       iReal1;
    logic                       iImg1;
    logic                       iReady;
    logic                       oBusy;
    logic                       oValid;
    logic signed [BITWIDTH:0]   oReal0;
    logic signed [BITWIDTH:0]   oImg0;
    logic signed [BITWIDTH:0]   oReal1;
    logic signed [BITWIDTH:0]   oImg1;

    modport slave (
        input  iEn, iStart, iReal0, iImg0, iReal1, iImg1, iReady,
        output oBusy, oValid, oReal0, oImg0, oReal1, oImg1
    );

    modport master (
        output iEn, iStart, iReal0, iImg0, iReal1, iImg1, iReady,
        input  oBusy, oValid, oReal0, oImg0, oReal1, oImg1
    );
endinterface

// File: rtl/ubutterfly_s2b.sv
// Stochastic-to-binary decoder for the butterfly stage outputs.
// Counts ones on four bipolar streams over 2^BITWIDTH enabled samples,
// converts each count C to 2C - L (saturated to BITWIDTH+1 signed) and
// offers the four results through a valid/ready handshake.
// Optional build macro S2B_SCALE_COMP_EN: results are additionally shifted
// left by SCALE and saturated to [-L, L-1].
module ubutterfly_s2b #(
    parameter int unsigned BITWIDTH = 8,
    parameter int unsigned SCALE    = 1
) (
    input  logic            iClk,
    input  logic            iRst,
    ubutterfly_s2b_if.slave bus
);
    localparam int unsigned L = 1 << BITWIDTH;

`ifdef S2B_SCALE_COMP_EN
    localparam int unsigned SCALE_EN = 1;
`else
    localparam int unsigned SCALE_EN = 0;
`endif

    // Without compensation the shift is zero; the common saturation stage then
    // only folds +L down to L-1, which is the plain conversion rule.
    localparam int unsigned SHIFT = SCALE * SCALE_EN;
    localparam int unsigned WW    = BITWIDTH + 2 + SHIFT;

    localparam logic signed [WW-1:0] MAXV = WW'(L - 1);
    localparam logic signed [WW-1:0] MINV = -MAXV - 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t                   stateQ;
    state_t                   stateD;
    logic [BITWIDTH-1:0]      winCnt;
    logic [BITWIDTH:0]        onesCnt  [4];
    logic [BITWIDTH:0]        onesNext [4];
    logic signed [BITWIDTH:0] result   [4];
    logic [3:0]               bits;
    logic                     lastSample;
    logic                     handshake;
    logic                     clearCnt;
    logic                     accumEn;
    logic                     loadRes;
    logic                     busy;
    logic                     valid;

    // Count C in 0..L to bipolar value, optional scale, saturate.
    function automatic logic signed [BITWIDTH:0] convert(input logic [BITWIDTH:0] count);
        logic [BITWIDTH+1:0]      diff;
        logic signed [WW-1:0]     wide;
        logic signed [BITWIDTH:0] res;
        // 2C - L lies in [-L, L], so modular arithmetic at BITWIDTH+2 bits is exact.
        diff = {count, 1'b0} - (BITWIDTH + 2)'(L);
        wide = WW'($signed(diff));
        wide = wide <<< SHIFT;
        if (wide > MAXV) begin
            res = MAXV[BITWIDTH:0];
        end else if (wide < MINV) begin
            res = MINV[BITWIDTH:0];
        end else begin
            res = wide[BITWIDTH:0];
        end
        return res;
    endfunction

    assign bits       = {bus.iImg1, bus.iReal1, bus.iImg0, bus.iReal0};
    assign lastSample = (stateQ == ACCUM) && bus.iEn && (&winCnt);
    assign handshake  = (stateQ == DONE) && bus.iReady;

    // State register.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    // Next-state logic: window start, last sample, result acceptance.
    always_comb begin
        stateD = stateQ;
        case (stateQ)
            IDLE: begin
                if (bus.iStart) begin
                    stateD = ACCUM;
                end
            end
            ACCUM: begin
                if (lastSample) begin
                    stateD = DONE;
                end
            end
            DONE: begin
                if (handshake) begin
                    stateD = bus.iStart ? ACCUM : IDLE;
                end
            end
            default: stateD = IDLE;
        endcase
    end

    // Output and datapath strobes decoded from the current state.
    always_comb begin
        busy     = (stateQ == ACCUM);
        valid    = (stateQ == DONE);
        clearCnt = ((stateQ == IDLE) && bus.iStart) || (handshake && bus.iStart);
        accumEn  = (stateQ == ACCUM) && bus.iEn;
        loadRes  = lastSample;
    end

    // Ones counts including the current input bit.
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            onesNext[i] = onesCnt[i] + {{BITWIDTH{1'b0}}, bits[i]};
        end
    end

    // Window and ones counters: cleared on window start, advance on enabled samples.
    always_ff @(posedge iClk) begin
        if (iRst || clearCnt) begin
            winCnt <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                onesCnt[i] <= '0;
            end
        end else if (accumEn) begin
            winCnt <= winCnt + 1'b1;
            for (int unsigned i = 0; i < 4; i++) begin
                onesCnt[i] <= onesNext[i];
            end
        end
    end

    // Result registers: loaded with the final counts (last sample included).
    always_ff @(posedge iClk) begin
        if (iRst) begin
            for (int unsigned i = 0; i < 4; i++) begin
                result[i] <= '0;
            end
        end else if (loadRes) begin
            for (int unsigned i = 0; i < 4; i++) begin
                result[i] <= convert(onesNext[i]);
            end
        end
    end

    assign bus.oBusy  = busy;
    assign bus.oValid = valid;
    assign bus.oReal0 = result[0];
    assign bus.oImg0  = result[1];
    assign bus.oReal1 = result[2];
    assign bus.oImg1  = result[3];
endmodule

// File: tb/tb_ubutterfly_s2b.sv
// Self-checking bench for ubutterfly_s2b with BITWIDTH=4 (L=16), SCALE=1.
// A window-level model tracks enabled samples and ones per stream and is
// compared against every output on every cycle; directed windows pin the
// model with hand-computed values, then randomized traffic follows.
module tb_ubutterfly_s2b;
    localparam int BW    = 4;
    localparam int L     = 16;
    localparam int SCALE = 1;

`ifdef S2B_SCALE_COMP_EN
    localparam int E12 = 15;    // 12 ones: 8 << 1 = 16, saturated
    localparam int E1  = -16;   // 1 one: -14 << 1 = -28, saturated
    localparam int E4  = -16;   // 4 ones: -8 << 1
`else
    localparam int E12 = 8;
    localparam int E1  = -14;
    localparam int E4  = -8;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    ubutterfly_s2b_if #(.BITWIDTH(BW)) bus ();

    ubutterfly_s2b #(
        .BITWIDTH(BW),
        .SCALE   (SCALE)
    ) dut (
        .iClk(clk),
        .iRst(rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Window-level model state.
    int mPhase = 0;   // 0 idle, 1 collecting, 2 holding results
    int mN     = 0;
    int mOnes[4];
    int mRes[4];
    bit mLive  = 1'b0;

    function automatic int conv(input int c);
        int v;
        v = 2 * c - L;
`ifdef S2B_SCALE_COMP_EN
        v = v * (1 << SCALE);
`endif
        if (v > L - 1) v = L - 1;
        if (v < -L) v = -L;
        return v;
    endfunction

    task automatic cmp(input string name, input logic signed [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on each rising edge from the inputs presented to it.
    always @(posedge clk) begin
        logic [3:0] b;
        b = {bus.iImg1, bus.iReal1, bus.iImg0, bus.iReal0};
        if (rst) begin
            mPhase = 0;
            mN     = 0;
            for (int i = 0; i < 4; i++) begin
                mOnes[i] = 0;
                mRes[i]  = 0;
            end
            mLive = 1'b1;
        end else if (mLive) begin
            case (mPhase)
                0: if (bus.iStart) begin
                    mPhase = 1;
                    mN     = 0;
                    for (int i = 0; i < 4; i++) mOnes[i] = 0;
                end
                1: if (bus.iEn) begin
                    for (int i = 0; i < 4; i++) mOnes[i] += int'(b[i]);
                    mN++;
                    if (mN == L) begin
                        for (int i = 0; i < 4; i++) mRes[i] = conv(mOnes[i]);
                        mPhase = 2;
                    end
                end
                default: if (bus.iReady) begin
                    if (bus.iStart) begin
                        mPhase = 1;
                        mN     = 0;
                        for (int i = 0; i < 4; i++) mOnes[i] = 0;
                    end else begin
                        mPhase = 0;
                    end
                end
            endcase
        end
    end

    // Compare every output against the model on the falling edge.
    always @(negedge clk) begin
        if (mLive) begin
            cmp("oBusy",  {31'b0, bus.oBusy},  (mPhase == 1) ? 1 : 0);
            cmp("oValid", {31'b0, bus.oValid}, (mPhase == 2) ? 1 : 0);
            cmp("oReal0", $signed(bus.oReal0), mRes[0]);
            cmp("oImg0",  $signed(bus.oImg0),  mRes[1]);
            cmp("oReal1", $signed(bus.oReal1), mRes[2]);
            cmp("oImg1",  $signed(bus.oImg1),  mRes[3]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setBits(input logic [3:0] b);
        bus.iReal0 = b[0];
        bus.iImg0  = b[1];
        bus.iReal1 = b[2];
        bus.iImg1  = b[3];
    endtask

    task automatic startPulse();
        bus.iStart = 1'b1;
        bus.iEn    = 1'b0;
        tick();
        bus.iStart = 1'b0;
    endtask

    // 16 enabled samples; optional disabled gap with all inputs high.
    task automatic body(input logic [15:0] r0, input logic [15:0] i0,
                        input logic [15:0] r1, input logic [15:0] i1,
                        input int gapAt, input int gapLen);
        for (int k = 0; k < L; k++) begin
            if (k == gapAt) begin
                for (int g = 0; g < gapLen; g++) begin
                    bus.iEn = 1'b0;
                    setBits(4'hF);
                    tick();
                end
            end
            bus.iEn = 1'b1;
            setBits({i1[k], r1[k], i0[k], r0[k]});
            if (k == L - 1) cmp("validBeforeLast", {31'b0, bus.oValid}, 0);
            tick();
        end
        bus.iEn = 1'b0;
        setBits(4'h0);
        cmp("validAfterLast", {31'b0, bus.oValid}, 1);
        cmp("busyAfterLast",  {31'b0, bus.oBusy},  0);
    endtask

    task automatic accept();
        bus.iReady = 1'b1;
        tick();
        bus.iReady = 1'b0;
    endtask

    task automatic expectAll(input int a, input int b, input int c, input int d);
        cmp("litReal0", $signed(bus.oReal0), a);
        cmp("litImg0",  $signed(bus.oImg0),  b);
        cmp("litReal1", $signed(bus.oReal1), c);
        cmp("litImg1",  $signed(bus.oImg1),  d);
    endtask

    initial begin
        int dens[4];
        bus.iEn    = 1'b0;
        bus.iStart = 1'b0;
        bus.iReady = 1'b0;
        setBits(4'h0);

        // Reset state.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        cmp("rstBusy",  {31'b0, bus.oBusy},  0);
        cmp("rstValid", {31'b0, bus.oValid}, 0);
        expectAll(0, 0, 0, 0);
        tick();

        // All ones saturates at +15.
        startPulse();
        body(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, -1, 0);
        expectAll(15, 15, 15, 15);
        accept();

        // All zeros gives -16.
        startPulse();
        body(16'h0000, 16'h0000, 16'h0000, 16'h0000, -1, 0);
        expectAll(-16, -16, -16, -16);
        accept();

        // Mixed densities: 8, 8, 1 and 12 ones.
        startPulse();
        body(16'hAAAA, 16'h00FF, 16'h0001, 16'h0FFF, -1, 0);
        expectAll(0, 0, E1, E12);
        accept();

        // Five disabled cycles mid-window with inputs high are not counted.
        startPulse();
        body(16'h000F, 16'hFFFF, 16'h0000, 16'hFFFF, 8, 5);
        expectAll(E4, 15, -16, 15);
        accept();

        // Stall in DONE with iStart pulses: results held, start ignored.
        startPulse();
        body(16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, -1, 0);
        for (int c = 0; c < 10; c++) begin
            bus.iStart = (c == 3 || c == 7);
            tick();
        end
        bus.iStart = 1'b0;
        cmp("stallValid", {31'b0, bus.oValid}, 1);
        expectAll(-16, 15, -16, 15);
        accept();
        cmp("idleBusy",  {31'b0, bus.oBusy},  0);
        cmp("idleValid", {31'b0, bus.oValid}, 0);

        // Back-to-back window: handshake with iStart goes straight to ACCUM.
        startPulse();
        body(16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF, -1, 0);
        expectAll(0, 0, 0, 0);
        bus.iReady = 1'b1;
        bus.iStart = 1'b1;
        tick();
        bus.iReady = 1'b0;
        bus.iStart = 1'b0;
        cmp("b2bBusy",  {31'b0, bus.oBusy},  1);
        cmp("b2bValid", {31'b0, bus.oValid}, 0);
        body(16'hFFFF, 16'h0000, 16'h0FFF, 16'hAAAA, -1, 0);
        expectAll(15, -16, E12, 0);
        accept();

        // Reset after seven samples discards the window.
        startPulse();
        bus.iEn = 1'b1;
        setBits(4'hF);
        for (int k = 0; k < 7; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.iEn = 1'b0;
        setBits(4'h0);
        cmp("midRstBusy",  {31'b0, bus.oBusy},  0);
        cmp("midRstValid", {31'b0, bus.oValid}, 0);
        expectAll(0, 0, 0, 0);
        startPulse();
        body(16'hAAAA, 16'h0FFF, 16'h0001, 16'hFFFF, -1, 0);
        expectAll(0, E12, E1, 15);
        accept();

        // Randomized traffic with per-stream densities.
        for (int i = 0; i < 4; i++) dens[i] = 2;
        for (int c = 0; c < 4000; c++) begin
            if (c % 64 == 0) begin
                for (int i = 0; i < 4; i++) dens[i] = int'($urandom_range(0, 4));
            end
            rst        = ($urandom_range(0, 299) == 0);
            bus.iEn    = ($urandom_range(0, 3) != 0);
            bus.iStart = ($urandom_range(0, 2) == 0);
            bus.iReady = ($urandom_range(0, 1) == 0);
            bus.iReal0 = (int'($urandom_range(0, 3)) < dens[0]);
            bus.iImg0  = (int'($urandom_range(0, 3)) < dens[1]);
            bus.iReal1 = (int'($urandom_range(0, 3)) < dens[2]);
            bus.iImg1  = (int'($urandom_range(0, 3)) < dens[3]);
            tick();
        end
        rst        = 1'b0;
        bus.iEn    = 1'b0;
        bus.iStart = 1'b0;
        bus.iReady = 1'b0;
        setBits(4'h0);
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ubutterfly_s2b.md
Name: ubutterfly_s2b

Overview:
- Output decoder for the stochastic butterfly stage. Sits directly downstream and consumes its four bipolar bitstreams (real/imag of outputs 0 and 1).
- Counts ones on each stream over a window of 2^BITWIDTH enabled cycles.
- Converts each count to a signed bipolar binary value.
- Presents the four results to the binary back end through a valid/ready handshake.

Parameters:
- BITWIDTH, 8, log2 of window length L = 2^BITWIDTH. Result width is BITWIDTH+1 signed.
- SCALE, 1, left-shift applied to results when S2B_SCALE_COMP_EN is defined. Compensates the 1/2 scaling of the non-scaled adders.

Ports:
- iClk  input  1  clock, rising edge.
- iRst  input  1  synchronous reset, active-high.
- iEn  input  1  sample enable. When low, bit counters and window counter hold.
- iStart  input  1  begin a new window (see FSM).
- iReal0  input  1  bipolar bitstream, butterfly real output 0.
- iImg0  input  1  bipolar bitstream, butterfly imag output 0.
- iReal1  input  1  bipolar bitstream, butterfly real output 1.
- iImg1  input  1  bipolar bitstream, butterfly imag output 1.
- iReady  input  1  consumer accepts results.
- oBusy  output  1  high in ACCUM.
- oValid  output  1  results valid, high in DONE.
- oReal0  output  BITWIDTH+1  signed result for iReal0.
- oImg0  output  BITWIDTH+1  signed result for iImg0.
- oReal1  output  BITWIDTH+1  signed result for iReal1.
- oImg1  output  BITWIDTH+1  signed result for iImg1.

Behaviour:
- Reset (iRst=1 at a clock edge) has priority over everything:
  - FSM goes to IDLE.
  - All counters are zeroed.
  - oBusy=0, oValid=0, all four results = 0.
  - Reset mid-window discards the partial window.
- FSM states:
  - IDLE: on iStart=1, go to ACCUM next cycle; clear the four ones-counters (BITWIDTH+1 bits each) and the window counter (BITWIDTH bits).
  - ACCUM, cycle with iEn=1: each ones-counter += its input bit; window counter += 1.
  - ACCUM, cycle with iEn=0: nothing changes; input bits are ignored.
  - ACCUM, sample taken with window counter = L-1: this is the last sample. Next cycle go to DONE; the result registers load the conversion of the final counts, including that last sample.
  - ACCUM: iStart is ignored.
  - DONE: oValid=1; results are held stable until handshake (oValid & iReady).
  - DONE, handshake with iStart=0: go to IDLE.
  - DONE, handshake with iStart=1: go directly to ACCUM with counters cleared (back-to-back windows).
  - DONE, no handshake: iStart is ignored.
- Conversion per stream, with ones-count C in 0..L:
  - V = 2C − L, computed at BITWIDTH+2 bits.
  - If V = +L, saturate to L−1. Otherwise V fits BITWIDTH+1 signed; range −L..L−1.
- Latency: oValid rises exactly 1 cycle after the edge that takes the L-th enabled sample.
- Result registers change only on the load into DONE and on reset. They keep their last value in IDLE/ACCUM, but are only meaningful while oValid=1.
- Minimum window period: L enabled cycles + 1 DONE cycle when iReady is held high.

Optional Feature:
- Macro S2B_SCALE_COMP_EN.
- Defined: after the conversion, each result is arithmetically left-shifted by SCALE, then saturated to [−L, L−1].
- Undefined: no shift; SCALE is unused.
- Handshake and latency are identical in both builds.

Test Plan:
- BITWIDTH=4 (L=16), iStart pulse, iEn=1, all four streams constant 1 for 16 cycles -> oValid rises 1 cycle after the 16th sample; all results = +15 (saturated); oBusy falls.
- Streams constant 0 -> all results = −16. iReal0 alternating 1/0 -> oReal0 = 0. iImg1 with 12 ones in 16 -> oImg1 = +8.
- iEn low for 5 cycles mid-window, inputs = 1 during the gap -> gap bits not counted; oValid appears after 16 enabled samples (21 cycles); counts match the enabled samples only.
- iReady held 0 for 10 cycles in DONE, iStart pulsed meanwhile -> oValid and results stable; iStart ignored; on iReady=1 FSM returns to IDLE. Then iReady=1 together with iStart=1 -> immediate ACCUM, no IDLE cycle.
- iRst asserted at window sample 7 -> next cycle oBusy=0, oValid=0, results 0. A new iStart then gives a full fresh 16-sample window with correct values.
- With S2B_SCALE_COMP_EN, SCALE=1: 12 ones -> +15 (16 saturated); 6 ones -> −8; 0 ones -> −16 (saturated).
